regfile_sb: RTL and testbench

Parametrised two-read/one-write register file with write-to-read bypass, optional hardwired zero register, asynchronous clear and an integrated per-register pending-write scoreboard. It sits in the decode stage of the pipelined core. Decode reads operands and hazard status in the same cycle. Issue reserves a destination register. Writeback delivers the result and releases the reservation.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_scoreboard.sv | 100 ++++++++++
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defaults for the decode-stage register file and its scoreboard,
//   plus the helper that derives the register address width from DEPTH.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Address width for a given register count. DEPTH must be a power of two
  // and at least 2. The guard keeps a degenerate DEPTH from giving a
  // zero-width address bus.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_sb_scoreboard.sv
// reg_scoreboard
//   Pending-write scoreboard for the register file. It keeps one busy bit per
//   register. Issue sets the bit and writeback clears it. The block also
//   produces the WAW-guard ready, the sticky protocol-error flag, and the
//   per-port busy outputs. Those busy outputs already account for a
//   writeback landing in the same cycle.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   we_i           writeback strobe
//   rd_addr_i      writeback register
//   iss_valid_i    request to reserve iss_addr_i
//   iss_addr_i     register to reserve
//   rs_addr_i      read port A register
//   rt_addr_i      read port B register
//   rs_busy_o      port A register has an outstanding producer
//   rt_busy_o      port B register has an outstanding producer
//   iss_ready_o    iss_addr_i may be reserved this cycle
//   err_o          sticky protocol error (rejected issue or orphan writeback)
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = calc_aw(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          iss_valid_i,
  input  logic [AW-1:0] iss_addr_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  output logic          rs_busy_o,
  output logic          rt_busy_o,
  output logic          iss_ready_o,
  output logic          err_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             err_q;
  logic             err_d;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // A writeback landing this cycle releases the producer, so a consumer
  // reading the same register is no longer stalled. The data reaches that
  // consumer through the bypass.
  function automatic logic port_busy(input logic [AW-1:0] a);
    return busy_q[a] && !(we_i && (rd_addr_i == a)) && !is_zero_reg(a);
  endfunction

  assign rs_busy_o = port_busy(rs_addr_i);
  assign rt_busy_o = port_busy(rt_addr_i);

  // WAW guard. A register may be reserved again only once its current
  // producer is gone, or is retiring in this same cycle.
  assign iss_ready_o = is_zero_reg(iss_addr_i) || !busy_q[iss_addr_i] ||
                       (we_i && (rd_addr_i == iss_addr_i));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (ZERO_REG && gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_live
        logic wb_hit;
        logic iss_hit;
        assign wb_hit  = we_i && (rd_addr_i == AW'(gi));
        assign iss_hit = iss_valid_i && iss_ready_o && (iss_addr_i == AW'(gi));
        // Issue takes priority over writeback. This lets a new producer
        // claim the register in the same cycle that the old one retires.
        assign busy_d[gi] = iss_hit | (busy_q[gi] & ~wb_hit);
      end
    end
  endgenerate

  // Address 0 is never an orphan writeback. With the zero register
  // disabled, r0 can still be written without first being reserved.
  assign err_d = err_q
               | (iss_valid_i && !iss_ready_o)
               | (we_i && (rd_addr_i != '0) && !busy_q[rd_addr_i]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule : reg_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb
//   Decode-stage register file with two read ports and one write port.
//   Reads are combinational. A writeback to the register being read in the
//   same cycle is bypassed to the read port. Register 0 can optionally be
//   hardwired to zero. An integrated scoreboard tracks registers that have an
//   outstanding producer. All state clears asynchronously on rst.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   Rs_addr / Rt_addr   read port A / B address
//   Rs_data / Rt_data   read port A / B data (bypassed)
//   Rs_busy / Rt_busy   read port A / B register has an outstanding producer
//   we, Rd_addr, Rd_data   writeback strobe, address, data
//   iss_valid, iss_addr    reserve iss_addr for a new producer
//   iss_ready           iss_addr may be reserved this cycle
//   err                 sticky protocol-error flag
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = calc_aw(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    Rs_addr,
  input  logic [AW-1:0]    Rt_addr,
  output logic [WIDTH-1:0] Rs_data,
  output logic [WIDTH-1:0] Rt_data,
  output logic             Rs_busy,
  output logic             Rt_busy,
  input  logic             we,
  input  logic [AW-1:0]    Rd_addr,
  input  logic [WIDTH-1:0] Rd_data,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_ready,
  output logic             err
);

  logic             wr_en;
  logic [WIDTH-1:0] rf_rd [DEPTH];

  // Writes to the hardwired zero register are dropped everywhere, including
  // the bypass path.
  assign wr_en = we && !(ZERO_REG && (Rd_addr == '0));

  // Storage is flops, not block RAM, because the array must clear
  // asynchronously and feed two combinational read ports.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG && gi == 0) begin : g_zero
        assign rf_rd[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        assign data_d = (wr_en && (Rd_addr == AW'(gi))) ? Rd_data : data_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_q <= '0;
          end else begin
            data_q <= data_d;
          end
        end
        assign rf_rd[gi] = data_q;
      end
    end
  endgenerate

  // Read ports with the writeback bypass. The zero register needs no extra
  // gating here, because rf_rd[0] is constant 0 and wr_en never targets it.
  always_comb begin
    Rs_data = rf_rd[Rs_addr];
    if (wr_en && (Rd_addr == Rs_addr)) begin
      Rs_data = Rd_data;
    end
  end

  always_comb begin
    Rt_data = rf_rd[Rt_addr];
    if (wr_en && (Rd_addr == Rt_addr)) begin
      Rt_data = Rd_data;
    end
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we),
    .rd_addr_i   (Rd_addr),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .rs_addr_i   (Rs_addr),
    .rt_addr_i   (Rt_addr),
    .rs_busy_o   (Rs_busy),
    .rt_busy_o   (Rt_busy),
    .iss_ready_o (iss_ready),
    .err_o       (err)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Directed test of regfile_sb. It uses a ZERO_REG=1 instance plus a
//   ZERO_REG=0 instance that shares the same inputs.
module tb_regfile_sb;

  localparam int W = 32;
  localparam int A = 5;

  logic         clk;
  logic         rst;
  logic [A-1:0] Rs_addr;
  logic [A-1:0] Rt_addr;
  logic         we;
  logic [A-1:0] Rd_addr;
  logic [W-1:0] Rd_data;
  logic         iss_valid;
  logic [A-1:0] iss_addr;

  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         rs_busy;
  logic         rt_busy;
  logic         iss_ready;
  logic         err;

  logic [W-1:0] nz_rs_data;
  logic [W-1:0] nz_rt_data;
  logic         nz_rs_busy;
  logic         nz_rt_busy;
  logic         nz_iss_ready;
  logic         nz_err;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.WIDTH(W), .DEPTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
    .Rs_data(rs_data), .Rt_data(rt_data),
    .Rs_busy(rs_busy), .Rt_busy(rt_busy),
    .we(we), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .err(err)
  );

  regfile_sb #(.WIDTH(W), .DEPTH(32), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst(rst),
    .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
    .Rs_data(nz_rs_data), .Rt_data(nz_rt_data),
    .Rs_busy(nz_rs_busy), .Rt_busy(nz_rt_busy),
    .we(we), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(nz_iss_ready), .err(nz_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: got %h ok", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 1'b0;
    iss_valid = 1'b0;
  endtask

  // Mid-cycle reset pulse, with no clock edge involved.
  task automatic rst_pulse();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [W-1:0] data_or;
    logic         busy_or;
    logic         ready_and;

    rst = 1'b1;
    Rs_addr = '0; Rt_addr = '0; we = 1'b0; Rd_addr = '0; Rd_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state: every address reads 0, not busy, and may be issued.
    data_or = '0; busy_or = 1'b0; ready_and = 1'b1;
    for (int a = 0; a < 32; a++) begin
      Rs_addr = A'(a); Rt_addr = A'(a); iss_addr = A'(a);
      #0.1;
      data_or   = data_or | rs_data | rt_data;
      busy_or   = busy_or | rs_busy | rt_busy;
      ready_and = ready_and & iss_ready;
    end
    check("rst_data", data_or, 0);
    check("rst_busy", W'(busy_or), 0);
    check("rst_ready", W'(ready_and), 1);
    check("rst_err", W'(err), 0);

    // Bypass: write r5 and read it in the same cycle.
    step();
    we = 1'b1; Rd_addr = 5'd5; Rd_data = 32'hDEADBEEF; Rs_addr = 5'd5;
    #1;
    check("bypass_r5", rs_data, 32'hDEADBEEF);
    check("err_before_orphan", W'(err), 0);
    step();
    we = 1'b0;
    #1;
    check("array_r5", rs_data, 32'hDEADBEEF);
    check("orphan_err", W'(err), 1);
    rst_pulse();
    check("async_rst_r5", rs_data, 0);
    check("async_rst_err", W'(err), 0);

    // Issue r7, then issue it again while it is still busy, then write it back.
    step();
    iss_valid = 1'b1; iss_addr = 5'd7; Rt_addr = 5'd7;
    #1;
    check("iss_ready_r7", W'(iss_ready), 1);
    check("r7_busy_same_cycle", W'(rt_busy), 0);
    step();
    iss_valid = 1'b0;
    #1;
    check("r7_busy_next", W'(rt_busy), 1);
    iss_valid = 1'b1;
    #1;
    check("waw_ready", W'(iss_ready), 0);
    check("waw_err_not_yet", W'(err), 0);
    step();
    iss_valid = 1'b0;
    #1;
    check("waw_err", W'(err), 1);
    check("r7_still_busy", W'(rt_busy), 1);
    we = 1'b1; Rd_addr = 5'd7; Rd_data = 32'h1234;
    #1;
    check("wb_r7_busy_fwd", W'(rt_busy), 0);
    check("wb_r7_bypass", rt_data, 32'h1234);
    step();
    we = 1'b0;
    #1;
    check("r7_busy_after_wb", W'(rt_busy), 0);
    check("r7_data_after_wb", rt_data, 32'h1234);
    rst_pulse();

    // Writeback and issue of r3 in the same cycle: the issue wins.
    step();
    iss_valid = 1'b1; iss_addr = 5'd3; Rs_addr = 5'd3;
    step();
    we = 1'b1; Rd_addr = 5'd3; Rd_data = 32'hA;
    #1;
    check("same_cycle_ready", W'(iss_ready), 1);
    check("same_cycle_bypass", rs_data, 32'hA);
    check("same_cycle_busy_fwd", W'(rs_busy), 0);
    step();
    idle();
    #1;
    check("same_cycle_busy_after", W'(rs_busy), 1);
    check("same_cycle_data_after", rs_data, 32'hA);
    check("same_cycle_err", W'(err), 0);
    rst_pulse();

    // Zero register: writes and issues to r0 are ignored when ZERO_REG=1,
    // but stored and tracked when ZERO_REG=0.
    step();
    we = 1'b1; Rd_addr = 5'd0; Rd_data = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_addr = 5'd0; Rs_addr = 5'd0; Rt_addr = 5'd0;
    #1;
    check("r0_bypass_blocked", rs_data, 0);
    check("r0_busy", W'(rs_busy), 0);
    check("r0_ready", W'(iss_ready), 1);
    step();
    idle();
    #1;
    check("r0_data_after", rs_data, 0);
    check("r0_busy_after", W'(rs_busy), 0);
    check("r0_err", W'(err), 0);
    check("r0_ready_after", W'(iss_ready), 1);
    check("nz_r0_rs_data", nz_rs_data, 32'hFFFFFFFF);
    check("nz_r0_rt_data", nz_rt_data, 32'hFFFFFFFF);
    check("nz_r0_rs_busy", W'(nz_rs_busy), 1);
    check("nz_r0_rt_busy", W'(nz_rt_busy), 1);
    check("nz_r0_ready", W'(nz_iss_ready), 0);
    check("nz_r0_err", W'(nz_err), 0);
    rst_pulse();

    // Asynchronous reset after writes to r1..r4 and an issue of r9.
    for (int r = 1; r <= 4; r++) begin
      step();
      we = 1'b1; Rd_addr = A'(r); Rd_data = 32'h11111111 * W'(r);
      iss_valid = (r == 2); iss_addr = 5'd9;
    end
    step();
    idle();
    Rs_addr = 5'd4; Rt_addr = 5'd9;
    #1;
    check("pre_rst_r4", rs_data, 32'h44444444);
    check("pre_rst_r9_busy", W'(rt_busy), 1);
    check("pre_rst_err", W'(err), 1);
    rst = 1'b1;
    #1;
    data_or = '0;
    for (int r = 1; r <= 4; r++) begin
      Rs_addr = A'(r);
      #1;
      data_or = data_or | rs_data;
    end
    check("mid_rst_data", data_or, 0);
    check("mid_rst_r9_busy", W'(rt_busy), 0);
    check("mid_rst_err", W'(err), 0);
    iss_addr = 5'd9;
    #1;
    check("mid_rst_ready", W'(iss_ready), 1);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_sb
